// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage: picks boot, sequential, stall or redirect PC each cycle.
// Optional macro PC_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VECTOR and adds misalignTrap_o.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int unsigned FLUSH_CYCLES = 1
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100
`endif
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] currentPC_i,
    input  logic        stall_i,
    input  logic        branchTaken_i,
    input  logic [63:0] branchTarget_i,
    output logic [63:0] nextPC_o,
    output logic        pcEnable_o,
    output logic        fetchValid_o,
    output logic        flushIF_o,
    output logic        flushID_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalignTrap_o,
`endif
    output logic [31:0] redirectCount_o,
    output logic [31:0] stallCycles_o
);

    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  flushCnt_q, flushCnt_d;
    logic [31:0] redirCnt_q, redirCnt_d;
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [63:0] pcPlus4;
    logic [63:0] redirectPC;

    assign pcPlus4 = currentPC_i + 64'd4;

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |branchTarget_i[1:0];
    assign redirectPC = misaligned ? TRAP_VECTOR : branchTarget_i;
`else
    assign redirectPC = branchTarget_i;
`endif

    // The branch is older than the stalled ID instruction, so a redirect always beats a stall.
    always_comb begin
        state_d      = state_q;
        flushCnt_d   = flushCnt_q;
        redirCnt_d   = redirCnt_q;
        stallCnt_d   = stallCnt_q;
        nextPC_o     = pcPlus4;
        pcEnable_o   = 1'b1;
        fetchValid_o = 1'b0;
        flushIF_o    = 1'b0;
        flushID_o    = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalignTrap_o = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                nextPC_o = RESET_VECTOR;
                state_d  = RUN;
            end
            default: begin
                if (branchTaken_i) begin
                    nextPC_o   = redirectPC;
                    flushIF_o  = !reset_i;
                    flushID_o  = !reset_i;
`ifdef PC_MISALIGN_TRAP_EN
                    misalignTrap_o = misaligned && !reset_i;
`endif
                    if (redirCnt_q != 32'hFFFF_FFFF) begin
                        redirCnt_d = redirCnt_q + 32'd1;
                    end
                    if (FLUSH_CYCLES == 0) begin
                        state_d    = RUN;
                        flushCnt_d = 4'd0;
                    end else begin
                        state_d    = FLUSH;
                        flushCnt_d = FLUSH_LOAD;
                    end
                end else if (state_q == FLUSH) begin
                    // Bubble fetches keep advancing the PC; the last bubble hands back to RUN.
                    if (flushCnt_q <= 4'd1) begin
                        state_d    = RUN;
                        flushCnt_d = 4'd0;
                    end else begin
                        flushCnt_d = flushCnt_q - 4'd1;
                    end
                end else if (stall_i) begin
                    nextPC_o   = currentPC_i;
                    pcEnable_o = 1'b0;
                    state_d    = STALL;
                    if (stallCnt_q != 32'hFFFF_FFFF) begin
                        stallCnt_d = stallCnt_q + 32'd1;
                    end
                end else begin
                    fetchValid_o = 1'b1;
                    state_d      = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= BOOT;
            flushCnt_q <= 4'd0;
            redirCnt_q <= 32'd0;
            stallCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            redirCnt_q <= redirCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign redirectCount_o = redirCnt_q;
    assign stallCycles_o   = stallCnt_q;

endmodule
